// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALUOp encodings and control bundle for the decode stage
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Unrecognised opcodes produce an all-zero bundle with only the illegal flag set.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_R;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALUOP_MEM;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_MEM;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_BR;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_MEM;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - register file with hardwired r0, write-first read ports and a debug port
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [NREG];
  logic              bypass_a;
  logic              bypass_b;

  // Storage; r0 is never written so it always holds zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign bypass_a = we && (raddr_a == waddr) && (raddr_a != '0);
  assign bypass_b = we && (raddr_b == waddr) && (raddr_b != '0);

  assign rdata_a  = (raddr_a == '0) ? '0 : (bypass_a ? wdata : mem[raddr_a]);
  assign rdata_b  = (raddr_b == '0) ? '0 : (bypass_b ? wdata : mem[raddr_b]);

  // The debug port shows committed state only, so it skips the bypass.
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/decode_stage_hazard.sv
// rtl/decode_stage_hazard.sv - ID stage with load-use stall, flush and ID/EX register; optional DECODE_STALL_CNT_EN adds stall_count
module decode_stage_hazard
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 11,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   current_pc,
  input  logic [DATA_W-1:0] write_back_data,
  input  logic [REG_AW-1:0] write_back_address,
  input  logic              RegWrite,
  input  logic              flush,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic              stall,
  output logic [DATA_W-1:0] dbg_data,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] sign_extended,
  output logic [PC_W-1:0]   jump_dest_addr,
  output logic [REG_AW-1:0] reg_dest_r_type,
  output logic [REG_AW-1:0] reg_dest_l_type,
  output logic              RegDst_out,
  output logic              ALUSrc_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              Branch_out,
  output logic [1:0]        ALUOp_out,
  output logic              illegal_out
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] sext;
  logic [PC_W-1:0]   target;
  ctrl_t             dec_ctrl;
  ctrl_t             ex_ctrl;
  logic              hz;

  assign rs  = instruction[21 +: REG_AW];
  assign rt  = instruction[16 +: REG_AW];
  assign rd  = instruction[11 +: REG_AW];
  assign imm = instruction[15:0];

  assign dec_ctrl = decode_ctrl(instruction[31:26]);

  assign sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign target = current_pc + {sext[PC_W-3:0], 2'b00};

  regfile_param #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we       (RegWrite),
    .waddr    (write_back_address),
    .wdata    (write_back_data),
    .raddr_a  (rs),
    .rdata_a  (rf_a),
    .raddr_b  (rt),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // A valid load in EX whose destination is a source of the valid instruction in ID.
  assign hz = in_valid && valid_out && ex_ctrl.mem_read && (reg_dest_l_type != '0) &&
              ((reg_dest_l_type == rs) || (reg_dest_l_type == rt));

  // A flush kills the dependent instruction anyway, so no stall is needed.
  assign stall = hz && !flush;

  // ID/EX register: datapath always loads; flush or hazard inserts a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out       <= 1'b0;
      ex_ctrl         <= '0;
      data_a          <= '0;
      data_b          <= '0;
      sign_extended   <= '0;
      jump_dest_addr  <= '0;
      reg_dest_r_type <= '0;
      reg_dest_l_type <= '0;
    end else begin
      data_a          <= rf_a;
      data_b          <= rf_b;
      sign_extended   <= sext;
      jump_dest_addr  <= target;
      reg_dest_r_type <= rd;
      reg_dest_l_type <= rt;
      if (flush || hz) begin
        valid_out <= 1'b0;
        ex_ctrl   <= '0;
      end else begin
        valid_out <= in_valid;
        ex_ctrl   <= in_valid ? dec_ctrl : '0;
      end
    end
  end

  assign RegDst_out   = ex_ctrl.reg_dst;
  assign ALUSrc_out   = ex_ctrl.alu_src;
  assign MemToReg_out = ex_ctrl.mem_to_reg;
  assign RegWrite_out = ex_ctrl.reg_write;
  assign MemRead_out  = ex_ctrl.mem_read;
  assign MemWrite_out = ex_ctrl.mem_write;
  assign Branch_out   = ex_ctrl.branch;
  assign ALUOp_out    = ex_ctrl.alu_op;
  assign illegal_out  = ex_ctrl.illegal;

`ifdef DECODE_STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_hazard.sv
// tb/tb_decode_stage_hazard.sv - scoreboard bench for decode_stage_hazard
module tb_decode_stage_hazard;

  localparam int DATA_W = 32;
  localparam int PC_W   = 11;
  localparam int REG_AW = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       instruction;
  logic              in_valid;
  logic [PC_W-1:0]   current_pc;
  logic [DATA_W-1:0] write_back_data;
  logic [REG_AW-1:0] write_back_address;
  logic              RegWrite;
  logic              flush;
  logic [REG_AW-1:0] dbg_addr;
  logic              stall;
  logic [DATA_W-1:0] dbg_data;
  logic              valid_out;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] sign_extended;
  logic [PC_W-1:0]   jump_dest_addr;
  logic [REG_AW-1:0] reg_dest_r_type;
  logic [REG_AW-1:0] reg_dest_l_type;
  logic              RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out;
  logic              MemRead_out, MemWrite_out, Branch_out;
  logic [1:0]        ALUOp_out;
  logic              illegal_out;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  decode_stage_hazard #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .REG_AW (REG_AW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .instruction        (instruction),
    .in_valid           (in_valid),
    .current_pc         (current_pc),
    .write_back_data    (write_back_data),
    .write_back_address (write_back_address),
    .RegWrite           (RegWrite),
    .flush              (flush),
    .dbg_addr           (dbg_addr),
    .stall              (stall),
    .dbg_data           (dbg_data),
    .valid_out          (valid_out),
    .data_a             (data_a),
    .data_b             (data_b),
    .sign_extended      (sign_extended),
    .jump_dest_addr     (jump_dest_addr),
    .reg_dest_r_type    (reg_dest_r_type),
    .reg_dest_l_type    (reg_dest_l_type),
    .RegDst_out         (RegDst_out),
    .ALUSrc_out         (ALUSrc_out),
    .MemToReg_out       (MemToReg_out),
    .RegWrite_out       (RegWrite_out),
    .MemRead_out        (MemRead_out),
    .MemWrite_out       (MemWrite_out),
    .Branch_out         (Branch_out),
    .ALUOp_out          (ALUOp_out),
    .illegal_out        (illegal_out)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_count        (stall_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                due;
    logic              chk_data;
    logic [10:0]       ctl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] se;
    logic [PC_W-1:0]   jd;
    logic [REG_AW-1:0] rr;
    logic [REG_AW-1:0] rl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [31:0] I_ADD_R3_R5_R0 = 32'h00A01820;
  localparam logic [31:0] I_ADDI_R7_R5   = 32'h20A7FFFF;
  localparam logic [31:0] I_ADD_R6_R0_R5 = 32'h00053020;
  localparam logic [31:0] I_SW_R5_8_R0   = 32'hAC050008;
  localparam logic [31:0] I_ILLEGAL      = 32'hFC000000;
  localparam logic [31:0] I_BEQ_P2       = 32'h10000002;
  localparam logic [31:0] I_BEQ_M1       = 32'h1000FFFF;
  localparam logic [31:0] I_LW_R2_4_R1   = 32'h8C220004;
  localparam logic [31:0] I_ADD_R4_R2_R3 = 32'h00432020;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bit order: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOp[1:0] illegal
  function automatic logic [9:0] exp_ctrl(input logic [5:0] op, input logic iv);
    if (!iv) return 10'b0;
    case (op)
      6'b000000: return 10'b1_0_0_1_0_0_0_10_0;
      6'b100011: return 10'b0_1_1_1_1_0_0_00_0;
      6'b101011: return 10'b0_1_0_0_0_1_0_00_0;
      6'b000100: return 10'b0_0_0_0_0_0_1_01_0;
      6'b001000: return 10'b0_1_0_1_0_0_0_00_0;
      default:   return 10'b0_0_0_0_0_0_0_00_1;
    endcase
  endfunction

  // Called just after a rising edge: drives ID inputs, checks stall, queues the ID/EX result.
  task automatic step(input logic [31:0] ins, input logic iv, input logic [PC_W-1:0] pc,
                      input logic fl, input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] ea, input logic [31:0] eb, input logic es, input logic bub);
    exp_t e;
    instruction        = ins;
    in_valid           = iv;
    current_pc         = pc;
    flush              = fl;
    RegWrite           = rw;
    write_back_address = wa;
    write_back_data    = wd;
    e.due      = cyc + 1;
    e.chk_data = !bub;
    e.ctl      = bub ? 11'b0 : {iv, exp_ctrl(ins[31:26], iv)};
    e.a        = ea;
    e.b        = eb;
    e.se       = {{16{ins[15]}}, ins[15:0]};
    e.jd       = PC_W'(int'(pc) + 4 * int'($signed(ins[15:0])));
    e.rr       = ins[15:11];
    e.rl       = ins[20:16];
    q.push_back(e);
    #1 check("stall", stall, es);
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares the ID/EX slot against the scoreboard on falling edges.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("slot_ctl",
            {valid_out, RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
             MemWrite_out, Branch_out, ALUOp_out, illegal_out}, e.ctl);
      if (e.chk_data)
        check("slot_data",
              {data_a, data_b, sign_extended, jump_dest_addr, reg_dest_r_type, reg_dest_l_type},
              {e.a, e.b, e.se, e.jd, e.rr, e.rl});
    end
  end

  initial begin
    int nz;
    int t;
    reset = 1'b1;
    instruction = '0; in_valid = 1'b0; current_pc = '0; write_back_data = '0;
    write_back_address = '0; RegWrite = 1'b0; flush = 1'b0; dbg_addr = '0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_slot",
          {stall, valid_out, RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
           MemWrite_out, Branch_out, ALUOp_out, illegal_out}, 0);
    check("reset_data",
          {data_a, data_b, sign_extended, jump_dest_addr, reg_dest_r_type, reg_dest_l_type}, 0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = REG_AW'(i);
      #1;
      if (dbg_data !== '0) nz++;
    end
    check("reset_dbg_nonzero_count", nz, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    //   instr            iv   pc      fl rw wa wd             a             b             stall bub
    step(I_ADD_R3_R5_R0, 1, 11'h010, 0, 1, 5, 32'h12345678, 32'h12345678, 32'h0,        0, 0);
    step(I_ADDI_R7_R5,   1, 11'h020, 0, 1, 0, 32'hFFFFFFFF, 32'h12345678, 32'h0,        0, 0);
    step(I_ADD_R6_R0_R5, 1, 11'h024, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        32'h12345678, 0, 0);
    dbg_addr = 0;
    #1 check("dbg_r0", dbg_data, 32'h0);
    dbg_addr = 5;
    #1 check("dbg_r5", dbg_data, 32'h12345678);
    step(I_SW_R5_8_R0,   0, 11'h028, 0, 0, 0, 32'h0,        32'h0,        32'h12345678, 0, 0);
    step(I_ILLEGAL,      1, 11'h100, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(I_BEQ_P2,       1, 11'h7FC, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);
    check("beq_p2_target", jump_dest_addr, 11'h004);
    step(I_BEQ_M1,       1, 11'h7FC, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);
    check("beq_m1_target", jump_dest_addr, 11'h7F8);
    step(I_LW_R2_4_R1,   1, 11'h040, 0, 1, 3, 32'hA5A5A5A5, 32'h0,        32'h0,        0, 0);
    step(I_ADD_R4_R2_R3, 1, 11'h044, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1);
    step(I_ADD_R4_R2_R3, 1, 11'h044, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 0);
    step(32'h0,          0, 11'h048, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(I_LW_R2_4_R1,   1, 11'h050, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);
    step(I_ADD_R4_R2_R3, 1, 11'h054, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1);
    step(I_ADD_R4_R2_R3, 1, 11'h058, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 0);
    step(I_LW_R2_4_R1,   1, 11'h060, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0);

    // Reset in the middle of a stall clears the load in EX, so stall falls at once.
    @(negedge clock);
    #1;
    instruction = I_ADD_R4_R2_R3;
    in_valid    = 1'b1;
    flush       = 1'b0;
    RegWrite    = 1'b0;
    #1 check("pre_reset_stall", stall, 1'b1);
    reset = 1'b1;
    #1 check("mid_stall_reset", {stall, valid_out, MemRead_out}, 3'b000);
    dbg_addr = 5;
    #1 check("reset_clears_r5", dbg_data, 32'h0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    t = 0;
    while (q.size() > 0 && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
